usb_tx_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares the single TX stream of the FTDI 245-FIFO controller among N_CH requester streams.
- Sits between application packet sources and the controller's tx_valid/tx_ready/tx_data port, in the same clock domain as tx_clk.
- Holds a grant for a whole packet and can optionally insert a tagging header beat before each packet so the host can demultiplex channels.

---
 rtl/usb_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_usb_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one FTDI TX stream among N_CH sources
// Optional per-packet tagging header beat is built when USB_TX_ARB_HDR_EN is defined.

module usb_tx_arbiter #(
   parameter int N_CH      = 4,
   parameter int DW        = 64,
   parameter int MAX_BEATS = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          in_valid,
   output logic [N_CH-1:0]          in_ready,
   input  logic [N_CH*DW-1:0]       in_data,
   input  logic [N_CH-1:0]          in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic                     out_last,
   output logic [$clog2(N_CH)-1:0]  grant_id,
   output logic                     busy
);
   localparam int GW = $clog2(N_CH);
   localparam int BW = $clog2(MAX_BEATS + 1);
   localparam logic [GW-1:0] LAST_CH  = GW'(N_CH - 1);
   localparam logic [BW-1:0] BEAT_LIM = BW'(MAX_BEATS - 1);

`ifdef USB_TX_ARB_HDR_EN
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
   localparam state_t S_GRANTED = S_HDR;
`else
   typedef enum logic {S_IDLE, S_DATA} state_t;
   localparam state_t S_GRANTED = S_DATA;
`endif

   state_t          state, state_nxt;
   logic [BW-1:0]   beat_cnt;
   logic            advance, any_valid, found, arb_fire;
   logic [GW-1:0]   rr_ptr, winner;
   logic [DW-1:0]   sel_data;
   logic            sel_valid, sel_last, beat_fire, pkt_end;

   assign advance   = ~out_valid | out_ready;
   assign any_valid = |in_valid;
   assign rr_ptr    = (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;
   assign arb_fire  = (state == S_IDLE) & any_valid & advance;
   assign beat_fire = (state == S_DATA) & sel_valid & advance;
   assign pkt_end   = sel_last | (beat_cnt == BEAT_LIM);

   // First requester at or after the rotating pointer wins.
   always_comb begin
      int idx;
      winner = rr_ptr;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!found && in_valid[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         if (GW'(c) == grant_id) begin
            sel_data  = in_data[c*DW +: DW];
            sel_valid = in_valid[c];
            sel_last  = in_last[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (arb_fire) state_nxt = S_GRANTED;
`ifdef USB_TX_ARB_HDR_EN
         S_HDR:   if (advance) state_nxt = S_DATA;
`endif
         S_DATA:  if (beat_fire && pkt_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef USB_TX_ARB_HDR_EN
   logic [7:0]    seq_cnt [N_CH];
   logic          hdr_load;
   logic [DW-1:0] hdr_beat;
`endif

   always_comb begin
      in_ready = '0;
      if (state == S_DATA) in_ready[grant_id] = advance;
      busy = (state != S_IDLE);
`ifdef USB_TX_ARB_HDR_EN
      hdr_load = (state == S_HDR) & advance;
      hdr_beat = '0;
      hdr_beat[DW-1 -: 8] = 8'hA5;
      hdr_beat[15:8]      = 8'(grant_id);
      hdr_beat[7:0]       = seq_cnt[grant_id];
`endif
   end

   // Single output register: a loaded beat stays put until the controller takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         grant_id  <= LAST_CH;
         beat_cnt  <= '0;
      end else begin
         if (arb_fire) grant_id <= winner;
         if (advance) begin
            out_valid <= 1'b0;
`ifdef USB_TX_ARB_HDR_EN
            if (hdr_load) begin
               out_valid <= 1'b1;
               out_data  <= hdr_beat;
               out_last  <= 1'b0;
            end
`endif
            if (beat_fire) begin
               out_valid <= 1'b1;
               out_data  <= sel_data;
               out_last  <= pkt_end;
            end
         end
         if (beat_fire) beat_cnt <= pkt_end ? '0 : beat_cnt + 1'b1;
      end
   end

`ifdef USB_TX_ARB_HDR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++) seq_cnt[c] <= 8'h00;
      end else if (beat_fire && pkt_end) begin
         seq_cnt[grant_id] <= seq_cnt[grant_id] + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - directed self-checking bench for usb_tx_arbiter (MAX_BEATS=4 build)

module tb_usb_tx_arbiter;
   localparam int N_CH = 4;
   localparam int DW = 64;
   localparam int MAX_BEATS = 4;
`ifdef USB_TX_ARB_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [N_CH-1:0] in_valid, in_ready, in_last;
   logic [N_CH*DW-1:0] in_data;
   logic out_valid, out_ready, out_last, busy;
   logic [DW-1:0] out_data;
   logic [1:0] grant_id;

   logic src_valid [N_CH];
   logic [DW-1:0] src_data [N_CH];
   logic src_last [N_CH];

   int checks = 0;
   int errors = 0;
   int exp_seq [N_CH];
   int hold_viol = 0;
   int multi_rdy = 0;
   logic [DW:0] cap_q[$];
   logic [DW:0] exp_q[$];
   logic [1:0] gid_q[$];
   logic [1:0] egid_q[$];
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic prev_last;

   usb_tx_arbiter #(.N_CH(N_CH), .DW(DW), .MAX_BEATS(MAX_BEATS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         in_valid[c] = src_valid[c];
         in_data[c*DW +: DW] = src_data[c];
         in_last[c] = src_last[c];
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            cap_q.push_back({out_last, out_data});
            gid_q.push_back(grant_id);
         end
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            hold_viol <= hold_viol + 1;
         if ($countones(in_ready) > 1) multi_rdy <= multi_rdy + 1;
         prev_stall <= out_valid && !out_ready;
         prev_data <= out_data;
         prev_last <= out_last;
      end
   end

   function automatic logic [DW-1:0] hdr(input int c, input int s);
      logic [DW-1:0] h;
      h = '0;
      h[DW-1 -: 8] = 8'hA5;
      h[15:8] = c[7:0];
      h[7:0] = s[7:0];
      return h;
   endfunction

   task automatic exp_pkt(input int c, input logic [DW-1:0] base, input int first, input int last_b);
      if (HDR) begin
         exp_q.push_back({1'b0, hdr(c, exp_seq[c])});
         egid_q.push_back(2'(c));
      end
      for (int b = first; b <= last_b; b++) begin
         exp_q.push_back({(b == last_b), base + 64'(b)});
         egid_q.push_back(2'(c));
      end
      exp_seq[c] = (exp_seq[c] + 1) % 256;
   endtask

   task automatic clear_q;
      cap_q.delete(); gid_q.delete(); exp_q.delete(); egid_q.delete();
   endtask

   task automatic send_pkt(input int c, input logic [DW-1:0] base, input int n);
      for (int b = 1; b <= n; b++) begin
         int t;
         src_valid[c] = 1'b1;
         src_data[c] = base + 64'(b);
         src_last[c] = (b == n);
         t = 0;
         do begin @(negedge clk); t++; end while (!in_ready[c] && t < 400);
         if (!in_ready[c]) begin
            checks++; errors++;
            $display("FAIL send_timeout ch%0d beat %0d: in_ready=0, required 1", c, b);
            src_valid[c] = 1'b0; src_last[c] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      src_valid[c] = 1'b0;
      src_last[c] = 1'b0;
   endtask

   task automatic wait_drain(input int n, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         if (cap_q.size() >= n && !busy && !out_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         src_valid[c] = 1'b0; src_data[c] = '0; src_last[c] = 1'b0; exp_seq[c] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0000", in_ready); end
      checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant_id: got %0d, expected 3", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, expected 0", out_last); end
   endtask

   task automatic test_single;
      bit ok;
      clear_q();
      exp_pkt(0, 64'h0, 1, 3);
      send_pkt(0, 64'h0, 3);
      wait_drain(exp_q.size(), ok);
      checks++; if (ok !== 1'b1 || cap_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d beats, expected %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
         checks++; if (gid_q[i] !== egid_q[i]) begin errors++; $display("FAIL single_gid%0d: got %0d, expected %0d", i, gid_q[i], egid_q[i]); end
      end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d, expected 0", grant_id); end
   endtask

   task automatic test_alternate;
      bit ok;
      int mr0;
      clear_q();
      mr0 = multi_rdy;
      for (int p = 0; p < 3; p++) begin
         exp_pkt(1, 64'(256 + p*16), 1, 2);
         exp_pkt(3, 64'(768 + p*16), 1, 2);
      end
      fork
         begin for (int p = 0; p < 3; p++) send_pkt(1, 64'(256 + p*16), 2); end
         begin for (int q = 0; q < 3; q++) send_pkt(3, 64'(768 + q*16), 2); end
      join
      wait_drain(exp_q.size(), ok);
      checks++; if (ok !== 1'b1 || cap_q.size() != exp_q.size()) begin errors++; $display("FAIL alt_count: got %0d beats, expected %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL alt_beat%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
         checks++; if (gid_q[i] !== egid_q[i]) begin errors++; $display("FAIL alt_gid%0d: got %0d, expected %0d", i, gid_q[i], egid_q[i]); end
      end
      checks++; if (multi_rdy !== mr0) begin errors++; $display("FAIL alt_onehot_ready: got %0d multi-ready cycles, expected 0", multi_rdy - mr0); end
   endtask

   task automatic test_stall;
      bit ok;
      int hv0;
      clear_q();
      hv0 = hold_viol;
      exp_pkt(2, 64'h200, 1, 4);
      exp_pkt(2, 64'h200, 5, 5);
      fork
         send_pkt(2, 64'h200, 5);
         begin
            for (int k = 0; k < 60; k++) begin out_ready = (k % 2 == 0); @(posedge clk); #1; end
            out_ready = 1'b1;
         end
      join
      wait_drain(exp_q.size(), ok);
      checks++; if (ok !== 1'b1 || cap_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d beats, expected %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
         checks++; if (gid_q[i] !== egid_q[i]) begin errors++; $display("FAIL stall_gid%0d: got %0d, expected %0d", i, gid_q[i], egid_q[i]); end
      end
      checks++; if (hold_viol !== hv0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles, expected 0", hold_viol - hv0); end
   endtask

   task automatic test_max_beats;
      bit ok;
      clear_q();
      exp_pkt(0, 64'h30, 1, 4);
      exp_pkt(1, 64'h140, 1, 2);
      exp_pkt(0, 64'h30, 5, 6);
      fork
         send_pkt(0, 64'h30, 6);
         send_pkt(1, 64'h140, 2);
      join
      wait_drain(exp_q.size(), ok);
      checks++; if (ok !== 1'b1 || cap_q.size() != exp_q.size()) begin errors++; $display("FAIL maxb_count: got %0d beats, expected %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxb_beat%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
         checks++; if (gid_q[i] !== egid_q[i]) begin errors++; $display("FAIL maxb_gid%0d: got %0d, expected %0d", i, gid_q[i], egid_q[i]); end
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int t;
      src_valid[2] = 1'b1; src_data[2] = 64'h2_0000; src_last[2] = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!in_ready[2] && t < 100);
      checks++; if (in_ready[2] !== 1'b1) begin errors++; $display("FAIL rmid_grant: in_ready[2]=%b, expected 1", in_ready[2]); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_inflight: out_valid=%b, expected 1", out_valid); end
      rst = 1'b1; src_valid[2] = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b, expected 0", out_valid); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rmid_in_ready: got %b, expected 0000", in_ready); end
      checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rmid_grant_id: got %0d, expected 3", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
      for (int c = 0; c < N_CH; c++) exp_seq[c] = 0;
      clear_q();
      exp_pkt(1, 64'h1100, 1, 1);
      exp_pkt(2, 64'h2200, 1, 1);
      fork
         send_pkt(1, 64'h1100, 1);
         send_pkt(2, 64'h2200, 1);
      join
      wait_drain(exp_q.size(), ok);
      checks++; if (ok !== 1'b1 || cap_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d beats, expected %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
         checks++; if (gid_q[i] !== egid_q[i]) begin errors++; $display("FAIL rmid_gid%0d: got %0d, expected %0d", i, gid_q[i], egid_q[i]); end
      end
   endtask

   task automatic test_seq_wrap;
      bit ok;
      clear_q();
      for (int p = 1; p <= 257; p++) exp_pkt(0, 64'(65536 + p*16), 1, 1);
      for (int p = 1; p <= 257; p++) send_pkt(0, 64'(65536 + p*16), 1);
      wait_drain(exp_q.size(), ok);
      checks++; if (ok !== 1'b1 || cap_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d beats, expected %0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         checks++; if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_beat%0d: got %h, expected %h", i, cap_q[i], exp_q[i]); end
      end
`ifdef USB_TX_ARB_HDR_EN
      checks++;
      if (cap_q.size() != 514 || cap_q[510][15:0] !== 16'h00FF || cap_q[512][15:0] !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_hdr_seq: pkt256/257 header low bits wrong (size %0d), expected 00ff then 0000", cap_q.size());
      end
`endif
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_stall();
      test_max_beats();
      test_reset_mid();
      test_seq_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
